xgmii_pause_rx: RTL and testbench
=================================

// Module: xgmii_pause_rx
// PURPOSE
//  Receive-side IEEE 802.3x PAUSE responder on the 64-bit XGMII RX path, between xphy_int and xgmac.
//  Parses MAC-control PAUSE frames, loads a quanta timer and holds pause_active high so TX stops.
//  It complements xgmac_int pause_req/pause_val: that block sends PAUSE, this one obeys it.
// PARAMETERS
//  C_MAC_ADDR       48'h000A35000001  station address; PAUSE is accepted to this DA or to 01-80-C2-00-00-01
//  C_QUANTA_CYCLES  8                 clk156 cycles per quantum (512 bit times / 64 bits per cycle); >=1
// PORTS
//  clk156          in   1   156.25 MHz core clock; the only clock
//  reset           in   1   asynchronous, active-high reset
//  xgmii_rxd       in   64  XGMII RX data, lane 0 = [7:0]
//  xgmii_rxc       in   8   XGMII RX control, bit n covers lane n
//  pause_enable    in   1   1 = obey received PAUSE; 0 = clear timer and ignore frames
//  pause_active    out  1   high while quanta timer is nonzero
//  pause_quanta    out  16  remaining quanta
//  pause_rx_valid  out  1   1-cycle pulse per accepted PAUSE frame
//  pause_frame_cnt out  32  accepted-frame count (present only with XGMII_PAUSE_STATS_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, prescaler = C_QUANTA_CYCLES-1, aligner cleared.
//  Aligner: input always registered. Start = rxc[0]&rxd[7:0]==FB (lane0) or rxc[4]&rxd[39:32]==FB (lane4).
//   Lane4 start: aligned word = {cur[31:0], prev[63:32]} until next start. Terminate FD, error FE.
//  FSM, one aligned word per cycle:
//   IDLE  -> HDR1 on start word; preamble/SFD is not checked.
//   HDR1  bytes0-5 DA (match C_MAC_ADDR or 0180C2000001), 6-7 SA -> HDR2 on match, else DISCARD.
//   HDR2  bytes0-3 SA, 4-5 EtherType==8808, 6-7 opcode==0001 -> HDR3 on match, else DISCARD.
//   HDR3  bytes0-1 quanta (byte0 = MSB), latched into q_hold -> WAIT_TERM.
//   WAIT_TERM: terminate in any lane (no FE seen) -> ACCEPT then IDLE; FE in any lane -> DISCARD.
//   DISCARD: -> IDLE on terminate or all-idle (rxc=FF, no start); PAUSE content is ignored.
//   A terminate or FE in HDR1..HDR3 -> IDLE with no accept. A start in any non-IDLE state aborts the
//    frame and goes to HDR1.
//  ACCEPT, when pause_enable=1: pause_rx_valid=1 for 1 cycle; pause_quanta<=q_hold; prescaler reloaded.
//   q_hold==0 drops pause_active on that same edge.
//   Latency: pulse 2 cycles after terminate word is sampled (lane0), 2-3 cycles (lane4).
//   A new PAUSE while active reloads the timer and overrides the old value.
//  Timer: while pause_quanta!=0 the prescaler counts down. At 0 it reloads and pause_quanta decrements.
//   pause_active = (pause_quanta!=0), registered. Quanta Q stays high exactly Q*C_QUANTA_CYCLES cycles.
//   No wrap below 0.
//  ACCEPT in the same cycle as the decrement: the reload wins.
//  pause_enable=0: pause_quanta<=0 next edge, no pulse; parsing continues.
//  reset mid-frame or mid-timer: immediate return to reset state.
// CONFIGURATION
//  XGMII_PAUSE_STATS_EN defined: pause_frame_cnt increments on each pause_rx_valid.
//   It saturates at FFFFFFFF and is cleared only by reset.
//  Not defined: port and counter logic are absent.
// TESTING
//  T1 lane0 PAUSE to 01-80-C2-00-00-01, quanta 0003, pause_enable=1 -> 1 pulse; pause_active high 24 cycles; pause_quanta 3->2->1->0.
//  T2 quanta FFFF, then 40 cycles later quanta 0000 -> timer reloads, pause_active falls on that accept edge.
//  T3 EtherType 0800 or opcode 0002 or DA mismatch -> no pulse, pause_active stays 0.
//  T4 FE in lane 3 of word 5 -> DISCARD, no pulse; next good PAUSE (quanta 0002) -> 16 cycles active.
//  T5 lane4 start, quanta 0001 -> accepted, 8 cycles active. Reset asserted mid-timer -> all outputs 0 asynchronously.
//  T6 (XGMII_PAUSE_STATS_EN) 5 good + 2 bad frames -> pause_frame_cnt==5. pause_enable=0 during a frame -> count unchanged.

Source files
------------

// File: rtl/xgmii_pause_rx.sv
// xgmii_pause_rx: 802.3x PAUSE responder on the 64-bit XGMII RX path; holds pause_active for received quanta
// Ports: clk156 / reset (async, active-high); xgmii_rxd / xgmii_rxc RX lanes (lane 0 = [7:0]);
//   pause_enable obeys received PAUSE; pause_active / pause_quanta timer state; pause_rx_valid accept pulse;
//   pause_frame_cnt saturating accept count, present only when XGMII_PAUSE_STATS_EN is defined.
module xgmii_pause_rx #(
  parameter logic [47:0] C_MAC_ADDR      = 48'h000A35000001,
  parameter int          C_QUANTA_CYCLES = 8
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        pause_enable,
  output logic        pause_active,
  output logic [15:0] pause_quanta,
  output logic        pause_rx_valid
`ifdef XGMII_PAUSE_STATS_EN
  ,
  output logic [31:0] pause_frame_cnt
`endif
);
  localparam int PW = C_QUANTA_CYCLES > 1 ? $clog2(C_QUANTA_CYCLES) : 1;
  localparam logic [PW-1:0] P_LOAD = PW'(C_QUANTA_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR3, WAIT_TERM, ACCEPT, DISCARD} state_t;
  state_t state;
  logic [63:0] cur_d, a;
  logic [31:0] prev_d;
  logic [7:0] cur_c, ac;
  logic [3:0] prev_c;
  logic lane4, s0, s4, sel, start, term, err, da_ok, typ_ok, tick;
  logic [47:0] da;
  logic [15:0] q_hold, q_next;
  logic [PW-1:0] presc;
  assign s0 = cur_c[0] && cur_d[7:0] == 8'hFB;
  assign s4 = cur_c[4] && cur_d[39:32] == 8'hFB;
  // a lane0 start realigns in its own cycle; a lane4 start shows up as an aligned start one word later
  assign sel = lane4 && !s0;
  assign a = sel ? {cur_d[31:0], prev_d} : cur_d;
  assign ac = sel ? {cur_c[3:0], prev_c} : cur_c;
  assign start = ac[0] && a[7:0] == 8'hFB;
  assign da = {a[7:0], a[15:8], a[23:16], a[31:24], a[39:32], a[47:40]};
  assign da_ok = da == C_MAC_ADDR || da == 48'h0180C2000001;
  assign typ_ok = {a[39:32], a[47:40], a[55:48], a[63:56]} == 32'h8808_0001;
  assign tick = pause_quanta != 16'd0 && presc == '0;
  always_comb begin
    term = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      term = term | (ac[i] && a[8*i +: 8] == 8'hFD);
      err = err | (ac[i] && a[8*i +: 8] == 8'hFE);
    end
  end
  // an accept reload wins over a same-cycle decrement
  assign q_next = !pause_enable ? 16'd0 : state == ACCEPT ? q_hold : tick ? pause_quanta - 16'd1 : pause_quanta;
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      cur_d <= '0;
      cur_c <= '0;
      prev_d <= '0;
      prev_c <= '0;
      lane4 <= 1'b0;
      state <= IDLE;
      q_hold <= '0;
      presc <= P_LOAD;
      pause_quanta <= '0;
      pause_active <= 1'b0;
      pause_rx_valid <= 1'b0;
    end else begin
      cur_d <= xgmii_rxd;
      cur_c <= xgmii_rxc;
      prev_d <= cur_d[63:32];
      prev_c <= cur_c[7:4];
      lane4 <= s0 ? 1'b0 : s4 ? 1'b1 : lane4;
      pause_quanta <= q_next;
      pause_active <= q_next != 16'd0;
      pause_rx_valid <= state == ACCEPT && pause_enable;
      presc <= (state == ACCEPT && pause_enable) || tick ? P_LOAD : pause_quanta != 16'd0 ? presc - 1'b1 : presc;
      if (start) state <= HDR1;
      else case (state)
        HDR1: state <= term || err ? IDLE : da_ok ? HDR2 : DISCARD;
        HDR2: state <= term || err ? IDLE : typ_ok ? HDR3 : DISCARD;
        HDR3: begin
          state <= term || err ? IDLE : WAIT_TERM;
          q_hold <= {a[7:0], a[15:8]};
        end
        WAIT_TERM: state <= err ? DISCARD : term ? ACCEPT : WAIT_TERM;
        DISCARD: state <= term || ac == 8'hFF ? IDLE : DISCARD;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef XGMII_PAUSE_STATS_EN
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) pause_frame_cnt <= '0;
    else if (pause_rx_valid && pause_frame_cnt != '1) pause_frame_cnt <= pause_frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_xgmii_pause_rx.sv
// tb_xgmii_pause_rx: randomized PAUSE frames against a frame-level reference model of xgmii_pause_rx
module tb_xgmii_pause_rx;
  localparam int QC = 8;
  localparam logic [47:0] MAC = 48'h000A35000001;
  localparam logic [47:0] BCAST = 48'h0180C2000001;
  typedef struct {int lo; int hi; logic [15:0] q;} pend_t;
  logic clk156 = 1'b0, reset = 1'b1, pause_enable = 1'b1;
  logic [63:0] xgmii_rxd = {8{8'h07}};
  logic [7:0] xgmii_rxc = 8'hFF;
  logic pause_active, pause_rx_valid;
  logic [15:0] pause_quanta;
`ifdef XGMII_PAUSE_STATS_EN
  logic [31:0] pause_frame_cnt;
`endif
  int checks = 0, errors = 0, cyc = 0, cnt_exp = 0, m_start = 0, k;
  logic [15:0] m_q = '0, eq;
  logic en_edge = 1'b1, mon_on = 1'b0;
  pend_t exp_q[$];
  pend_t e;
  xgmii_pause_rx #(.C_MAC_ADDR(MAC), .C_QUANTA_CYCLES(QC)) dut (
    .clk156(clk156), .reset(reset), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .pause_enable(pause_enable), .pause_active(pause_active), .pause_quanta(pause_quanta),
    .pause_rx_valid(pause_rx_valid)
`ifdef XGMII_PAUSE_STATS_EN
    , .pause_frame_cnt(pause_frame_cnt)
`endif
  );
  always #5 clk156 = ~clk156;
  always @(posedge clk156) begin
    cyc <= cyc + 1;
    en_edge <= pause_enable;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // timer reference: quanta Q accepted at cycle s reads max(0, Q - (t-s)/QC) at cycle t
  always @(negedge clk156) if (mon_on) begin
    if (pause_rx_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_in_window", cyc >= e.lo && cyc <= e.hi, 1);
        m_q = e.q;
        m_start = cyc;
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
      e = exp_q.pop_front();
      chk("missing_pulse", 0, 1);
    end
    if (!en_edge) m_q = '0;
    k = (cyc - m_start) / QC;
    eq = int'(m_q) > k ? m_q - 16'(k) : 16'd0;
    chk("quanta", pause_quanta, eq);
    chk("active", pause_active, eq != 16'd0);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk156);
      xgmii_rxd = {8{8'h07}};
      xgmii_rxc = 8'hFF;
    end
  endtask
  task automatic send(input bit l4, input logic [47:0] da, input logic [15:0] et,
                      input logic [15:0] op, input logic [15:0] q, input int fe);
    logic [8:0] b[$];
    int tpos;
    bit ok;
    pend_t p;
    ok = pause_enable && (da == MAC || da == BCAST) && et == 16'h8808 && op == 16'h0001 && fe < 0;
    if (l4) repeat (4) b.push_back({1'b1, 8'h07});
    b.push_back({1'b1, 8'hFB});
    repeat (6) b.push_back({1'b0, 8'h55});
    b.push_back({1'b0, 8'hD5});
    for (int i = 5; i >= 0; i--) b.push_back({1'b0, da[8*i +: 8]});
    repeat (6) b.push_back({1'b0, 8'($urandom)});
    b.push_back({1'b0, et[15:8]});
    b.push_back({1'b0, et[7:0]});
    b.push_back({1'b0, op[15:8]});
    b.push_back({1'b0, op[7:0]});
    b.push_back({1'b0, q[15:8]});
    b.push_back({1'b0, q[7:0]});
    repeat (46) b.push_back({1'b0, 8'($urandom)});
    if (fe >= 0) b[(l4 ? 4 : 0) + fe] = {1'b1, 8'hFE};
    tpos = b.size();
    b.push_back({1'b1, 8'hFD});
    while (b.size() % 8 != 0) b.push_back({1'b1, 8'h07});
    for (int w = 0; w < b.size() / 8; w++) begin
      @(negedge clk156);
      for (int j = 0; j < 8; j++) begin
        xgmii_rxd[8*j +: 8] = b[8*w+j][7:0];
        xgmii_rxc[j] = b[8*w+j][8];
      end
      if (ok && w == tpos / 8) begin
        p.lo = cyc + 3;
        p.hi = cyc + (l4 ? 4 : 3);
        p.q = q;
        exp_q.push_back(p);
        cnt_exp++;
      end
    end
    idle(4);
  endtask
  initial begin
    logic [47:0] da;
    repeat (3) @(negedge clk156);
    chk("rst_active", pause_active, 0);
    chk("rst_quanta", pause_quanta, 0);
    chk("rst_valid", pause_rx_valid, 0);
    reset = 1'b0;
    mon_on = 1'b1;
    idle(2);
    send(0, BCAST, 16'h8808, 16'h0001, 16'h0003, -1);
    idle(30);
    send(0, MAC, 16'h8808, 16'h0001, 16'hFFFF, -1);
    idle(40);
    send(0, MAC, 16'h8808, 16'h0001, 16'h0000, -1);
    idle(5);
    send(0, MAC, 16'h0800, 16'h0001, 16'h0005, -1);
    send(0, BCAST, 16'h8808, 16'h0002, 16'h0005, -1);
    send(0, 48'h000A35000002, 16'h8808, 16'h0001, 16'h0005, -1);
    send(0, MAC, 16'h8808, 16'h0001, 16'h0007, 43);
    send(0, MAC, 16'h8808, 16'h0001, 16'h0002, -1);
    idle(25);
    send(1, BCAST, 16'h8808, 16'h0001, 16'h0001, -1);
    idle(12);
    pause_enable = 1'b0;
    send(0, MAC, 16'h8808, 16'h0001, 16'h0004, -1);
    pause_enable = 1'b1;
    for (int n = 0; n < 40; n++) begin
      da = $urandom_range(0, 3) == 0 ? 48'h000A35000002 : ($urandom_range(0, 1) ? MAC : BCAST);
      if ($urandom_range(0, 7) == 0) pause_enable = 1'b0;
      send(1'($urandom_range(0, 1)), da,
           $urandom_range(0, 5) == 0 ? 16'h0800 : 16'h8808,
           $urandom_range(0, 5) == 0 ? 16'h0002 : 16'h0001,
           16'($urandom_range(0, 12)),
           $urandom_range(0, 5) == 0 ? int'($urandom_range(8, 71)) : -1);
      pause_enable = 1'b1;
      idle($urandom_range(0, 3));
    end
    idle(120);
`ifdef XGMII_PAUSE_STATS_EN
    chk("frame_cnt", pause_frame_cnt, cnt_exp);
`endif
    send(0, MAC, 16'h8808, 16'h0001, 16'h0005, -1);
    idle(10);
    @(negedge clk156);
    mon_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_active", pause_active, 0);
    chk("async_rst_quanta", pause_quanta, 0);
    chk("async_rst_valid", pause_rx_valid, 0);
`ifdef XGMII_PAUSE_STATS_EN
    chk("async_rst_cnt", pause_frame_cnt, 0);
`endif
    @(negedge clk156);
    reset = 1'b0;
    m_q = '0;
    exp_q.delete();
    mon_on = 1'b1;
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
